// File: rtl/dual_port_ram_init.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_ram_init
// Description : Simple-dual-port RAM with one byte-enabled write port, one
//               registered read port, selectable read-during-write result and
//               a hardware clear engine that writes INIT_VALUE to every
//               location after reset.
// Ports       : clk, rst        - clock and synchronous active-high reset
//               wr_en/wr_addr/wr_data/wr_be - write request with byte enables
//               rd_en/rd_addr   - read request
//               rd_data         - registered read data
//               rd_valid        - rd_data was updated by the previous edge
//               busy            - clear engine active, requests ignored
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram_init #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DEPTH      = 64,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy
);

    localparam int                  NUM_BYTES   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] C_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH:0]   clr_addr_q, clr_addr_d;
    logic                  busy_q,     busy_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

    // Single memory write port shared by the clear engine and the user port.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_BYTES-1:0]  mem_wbe;

    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  wr_in_range;
    logic                  rd_in_range;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            be_mask[8*i +: 8] = {8{wr_be[i]}};
        end
    end

    assign wr_in_range = ({1'b0, wr_addr} < C_DEPTH);
    assign rd_in_range = ({1'b0, rd_addr} < C_DEPTH);
    // Only consumed when rd_addr is in range.
    assign rd_old      = mem[rd_addr];
    // Word as it will look after this edge's write, for write-first reads.
    assign wr_merged   = (rd_old & ~be_mask) | (wr_data & be_mask);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy_d     = busy_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
        mem_wbe    = wr_be;

        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_addr   = clr_addr_q[ADDR_WIDTH-1:0];
                mem_wdata  = INIT_VALUE;
                mem_wbe    = '1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == C_LAST_ADDR) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                mem_we = wr_en && wr_in_range;
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    if (!rd_in_range) begin
                        rd_data_d = '0;
                    end else if ((RDW_MODE != 0) && mem_we && (wr_addr == rd_addr)) begin
                        rd_data_d = wr_merged;
                    end else begin
                        rd_data_d = rd_old;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage has no reset; the clear engine initialises it after rst drops.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_ram_init
// Description : Self-checking bench for dual_port_ram_init. Two instances
//               share one stimulus stream: A (DEPTH=64, read-first) and
//               B (DEPTH=48, write-first), both 32-bit wide. A word-level
//               memory model per instance predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_init;

    localparam logic [31:0] C_INIT_A = 32'hA5A5_A5A5;
    localparam logic [31:0] C_INIT_B = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    dual_port_ram_init #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(64), .RDW_MODE(0), .INIT_VALUE(C_INIT_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .busy(busy_a)
    );

    dual_port_ram_init #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48), .RDW_MODE(1), .INIT_VALUE(C_INIT_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state, index 0 = instance A, 1 = instance B.
    logic [31:0] m_mem   [2][64];
    int          clr_cnt [2];
    bit          rdy     [2];
    logic [31:0] e_data  [2];
    bit          e_valid [2];
    bit          e_busy  [2];
    bit          known = 1'b0;

    function automatic int depth_of(int k);
        return (k == 0) ? 64 : 48;
    endfunction

    function automatic logic [31:0] init_of(int k);
        return (k == 0) ? C_INIT_A : C_INIT_B;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [31:0] nw;
        bit          wr_ok;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                known      = 1'b1;
                clr_cnt[k] = 0;
                rdy[k]     = 1'b0;
                e_busy[k]  = 1'b1;
                e_valid[k] = 1'b0;
                e_data[k]  = '0;
            end else if (!rdy[k]) begin
                m_mem[k][clr_cnt[k]] = init_of(k);
                clr_cnt[k]++;
                if (clr_cnt[k] == depth_of(k)) rdy[k] = 1'b1;
                e_busy[k]  = !rdy[k];
                e_valid[k] = 1'b0;
            end else begin
                wr_ok = wr_en && (int'(wr_addr) < depth_of(k));
                nw    = m_mem[k][wr_addr];
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b]) nw[8*b +: 8] = wr_data[8*b +: 8];
                end
                e_valid[k] = rd_en;
                if (rd_en) begin
                    if (int'(rd_addr) >= depth_of(k))
                        e_data[k] = '0;
                    else if (k == 1 && wr_ok && wr_addr == rd_addr)
                        e_data[k] = nw;
                    else
                        e_data[k] = m_mem[k][rd_addr];
                end
                if (wr_ok) m_mem[k][wr_addr] = nw;
            end
        end
    endtask

    // One clock: model prediction, edge, then the per-cycle comparison.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (known) begin
            chk("busy_a",     32'(busy_a),     32'(e_busy[0]));
            chk("rd_valid_a", 32'(rd_valid_a), 32'(e_valid[0]));
            chk("rd_data_a",  rd_data_a,       e_data[0]);
            chk("busy_b",     32'(busy_b),     32'(e_busy[1]));
            chk("rd_valid_b", 32'(rd_valid_b), 32'(e_valid[1]));
            chk("rd_data_b",  rd_data_b,       e_data[1]);
        end
    endtask

    task automatic op(input bit we, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit re, input logic [5:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        tick();
    endtask

    task automatic idle();
        op(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0);
    endtask

    task automatic rd(input logic [5:0] ra);
        op(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, ra);
    endtask

    // Run until both clear engines finish; return edges each spent busy.
    task automatic wait_clear(input bit with_req, output int ta, output int tb);
        int cnt;
        cnt = 0; ta = 0; tb = 0;
        while ((busy_a || busy_b) && cnt < 200) begin
            if (with_req && cnt < 40) op(1'b1, 6'd1, 32'h55, 4'hF, 1'b1, 6'd1);
            else                      idle();
            cnt++;
            if (!busy_a && ta == 0) ta = cnt;
            if (!busy_b && tb == 0) tb = cnt;
        end
        if (cnt >= 200) chk("clear_timeout", 32'(cnt), 32'd0);
    endtask

    int ta, tb;

    initial begin
        // Reset state
        repeat (3) idle();
        chk("reset_busy_a",  32'(busy_a),     32'd1);
        chk("reset_valid_a", 32'(rd_valid_a), 32'd0);
        chk("reset_data_a",  rd_data_a,       32'd0);

        // Clear with requests applied while busy
        rst = 1'b0;
        wait_clear(1'b1, ta, tb);
        chk("clear_len_a", 32'(ta), 32'd64);
        chk("clear_len_b", 32'(tb), 32'd48);

        // Initial contents
        rd(6'd0);  chk("init0_a", rd_data_a, C_INIT_A);
        rd(6'd31); chk("init31_a", rd_data_a, C_INIT_A);
        rd(6'd63); chk("init63_a", rd_data_a, C_INIT_A);
                   chk("oor63_b", rd_data_b, 32'd0);
                   chk("oor63_valid_b", 32'(rd_valid_b), 32'd1);
        rd(6'd1);  chk("busyreq1_a", rd_data_a, C_INIT_A);
                   chk("busyreq1_b", rd_data_b, C_INIT_B);

        // Byte-enable merge
        op(1'b1, 6'd5, 32'h1122_3344, 4'hF, 1'b0, 6'd0);
        op(1'b1, 6'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, 6'd0);
        rd(6'd5);  chk("merge_a", rd_data_a, 32'h11BB_33DD);
                   chk("merge_b", rd_data_b, 32'h11BB_33DD);

        // Read-during-write
        op(1'b1, 6'd2, 32'h03, 4'hF, 1'b0, 6'd0);
        op(1'b1, 6'd2, 32'h7E, 4'hF, 1'b1, 6'd2);
        chk("rdw_first_a", rd_data_a, 32'h03);
        chk("rdw_first_b", rd_data_b, 32'h7E);
        rd(6'd2);  chk("rdw_next_a", rd_data_a, 32'h7E);
                   chk("rdw_next_b", rd_data_b, 32'h7E);
        op(1'b1, 6'd3, 32'hFFFF_1234, 4'b0011, 1'b1, 6'd3);
        chk("rdw_part_a", rd_data_a, C_INIT_A);
        chk("rdw_part_b", rd_data_b, 32'h5A5A_1234);

        // Out-of-range write/read (only B treats 50 as out of range)
        op(1'b1, 6'd50, 32'hFF, 4'hF, 1'b0, 6'd0);
        rd(6'd50); chk("oor50_a", rd_data_a, 32'hFF);
                   chk("oor50_b", rd_data_b, 32'h0);
        rd(6'd47); chk("edge47_a", rd_data_a, C_INIT_A);
                   chk("edge47_b", rd_data_b, C_INIT_B);

        // Independent addresses on one edge, then a hold cycle
        op(1'b1, 6'd7, 32'hCAFE_BABE, 4'hF, 1'b1, 6'd5);
        chk("indep_a", rd_data_a, 32'h11BB_33DD);
        idle();
        chk("hold_a", rd_data_a, 32'h11BB_33DD);
        chk("hold_valid_a", 32'(rd_valid_a), 32'd0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 48; i++) begin
            op((i % 3) != 2, 6'((i * 7) % 64), {8'(i), 8'(~i), 8'(i * 3), 8'(i + 17)},
               4'(i % 16), (i % 4) != 3, 6'((i * 5 + 3) % 64));
        end

        // Reset in READY, then again mid-CLEAR at step 20
        op(1'b1, 6'd10, 32'h42, 4'hF, 1'b0, 6'd0);
        rd(6'd10); chk("pre_rst10_a", rd_data_a, 32'h42);
        rst = 1'b1; idle();
        rst = 1'b0;
        repeat (20) idle();
        rst = 1'b1; idle();
        rst = 1'b0;
        wait_clear(1'b0, ta, tb);
        chk("reclear_len_a", 32'(ta), 32'd64);
        chk("reclear_len_b", 32'(tb), 32'd48);
        rd(6'd10); chk("post_rst10_a", rd_data_a, C_INIT_A);
                   chk("post_rst10_b", rd_data_b, C_INIT_B);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_port_ram_init.md
# dual_port_ram_init

Parametrised simple-dual-port RAM: one write port with per-byte enables, one registered read port, selectable read-during-write behaviour, and a hardware clear engine that initialises every location after reset. It succeeds the single-port RAM as the general storage primitive for buffers and register files. Any other block that needs known-clean memory contents after reset can use it without a software init loop.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6: address width.
- DEPTH, 64: number of words; 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- RDW_MODE, 0: same-address read-during-write result; 0 = read-first (old data), 1 = write-first (new data).
- INIT_VALUE, 0: DATA_WIDTH-bit word written to every location by the clear engine.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i enables byte [8i+7:8i].
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  rd_data was updated by the previous edge's read.
- busy  output  1  clear engine active; requests are ignored.

## Operation
- Two-state FSM: CLEAR and READY; a clr_addr counter is ADDR_WIDTH+1 bits wide.
- Reset values, applied on an edge with rst=1: state=CLEAR, clr_addr=0, busy=1, rd_valid=0, rd_data=0.
- While rst is held, the FSM stays in CLEAR, clr_addr stays 0, and no memory write occurs.
- CLEAR, each edge with rst=0:
  - mem[clr_addr] ← INIT_VALUE, then clr_addr increments.
  - The edge that writes DEPTH-1 moves state to READY and sets busy=0.
- In CLEAR, wr_en and rd_en are ignored: no user write, rd_valid stays 0, and rd_data holds.
- READY write, wr_en=1 with wr_addr<DEPTH:
  - Each byte i with wr_be[i]=1 is updated from wr_data.
  - Bytes with wr_be[i]=0 are unchanged.
  - wr_be=0 is a legal no-op.
- wr_addr ≥ DEPTH: the write is dropped and no location is modified.
- READY read, rd_en=1:
  - rd_data ← mem[rd_addr], and rd_valid ← 1.
  - If rd_addr ≥ DEPTH, rd_data ← 0 and rd_valid ← 1.
- rd_en=0: rd_valid ← 0 and rd_data holds its last value.
- Same-edge write and read to the same in-range address:
  - RDW_MODE=0: rd_data returns the pre-write word.
  - RDW_MODE=1: rd_data returns the post-write word, i.e. enabled bytes from wr_data and the other bytes from the old contents.
- Different addresses on the same edge are fully independent.
- rst asserted mid-CLEAR restarts the clear from address 0.
- rst asserted in READY re-enters CLEAR; all contents are re-initialised.

## Timing
- Read latency is 1 cycle: a request sampled at edge N yields rd_data/rd_valid driven after edge N, valid for sampling at edge N+1.
- Write latency is 1 cycle: a write at edge N is visible to a read sampled at edge N+1. At edge N itself, see RDW_MODE.
- Clear duration:
  - Let E0 be the first edge with rst=0. Edges E0 … E(DEPTH-1) perform the clears.
  - busy falls after E(DEPTH-1).
  - The first accepted request is at E(DEPTH).
- busy is registered; there is no combinational path from any input to any output.
- No back-pressure exists: requests made while busy=1 are dropped, not queued. Callers must gate on busy.

## Test plan
- Clear and init contents, DEPTH=64, INIT_VALUE=8'hA5:
  - Stimulus: release rst, then read addresses 0, 31 and 63.
  - Required: busy stays high for exactly 64 edges; each read returns 8'hA5 with rd_valid=1 one cycle after the request.
- Byte-enable merge, DATA_WIDTH=32, RDW_MODE=0:
  - Stimulus: write 32'h11223344 be=4'hF to addr 5, then 32'hAABBCCDD be=4'b0101 to addr 5, then read addr 5.
  - Required: reads return 32'h11BB33DD.
- Read-during-write on addr 2, old contents 8'h03, write 8'h7E on the same edge:
  - RDW_MODE=0 returns 8'h03; RDW_MODE=1 returns 8'h7E.
  - A read on the next edge returns 8'h7E in both modes.
- Out-of-range access, ADDR_WIDTH=6, DEPTH=48:
  - Stimulus: write 8'hFF to addr 50, then read addr 50 and addr 47.
  - Required: addr 50 returns 0 with rd_valid=1; addr 47 keeps INIT_VALUE.
- Requests while busy:
  - Stimulus: assert wr_en/rd_en to addr 1 with data 8'h55 during CLEAR.
  - Required: rd_valid stays 0; after busy falls, addr 1 reads INIT_VALUE.
- Reset mid-operation:
  - Stimulus: write 8'h42 to addr 10 in READY; pulse rst at clear step 20, then run to completion.
  - Required: busy lasts 64 edges after the second release; addr 10 reads INIT_VALUE.
